// File: rtl/microwave_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : microwave_controller_if                                 |
// | Description : Front-panel bundle between the keypad/buttons/door      |
// |               switch/displays and the microwave controller core.      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
interface microwave_controller_if;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       mag_on;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] min_ones_segs;
  logic [6:0] min_tens_segs;

  // Panel side: drives the buttons and reads back magnetron/display state
  modport master (
    output keypad, startn, stopn, clearn, door_closed,
    input  mag_on, sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs
  );

  // Controller side
  modport slave (
    input  keypad, startn, stopn, clearn, door_closed,
    output mag_on, sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs
  );
endinterface
`default_nettype wire

// File: rtl/microwave_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : microwave_controller                                    |
// | Description : Microwave front-panel controller. Keypad entry into an  |
// |               MM:SS BCD timer, 1 s countdown while cooking, magnetron |
// |               enable, door interlock and four 7-segment digits.       |
// | Option      : MW_LEADING_ZERO_BLANK_EN - blank leading minute zeros   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module microwave_controller #(
  parameter int TICK_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  microwave_controller_if.slave panel
);

  localparam int c_PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic [15:0]     r_time, w_time_nx;   // {mt, mo, st, so}
  logic [c_PW-1:0] r_presc, w_presc_nx;
  logic            r_mag_on;
  logic            r_startn_q, r_stopn_q;
  logic [9:0]      r_keypad_q;
  logic            w_start_evt, w_stop_evt, w_key_evt;
  logic [3:0]      w_digit;
  logic [15:0]     w_time_dec;

  // One-second decrement of the MM:SS BCD value. Seconds above 59 are not
  // normalised; they simply count down until a borrow reaches them.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else begin
      st = 4'd5;
      so = 4'd9;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mo = 4'd9;
        mt = mt - 4'd1;
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Segment pattern {g,f,e,d,c,b,a}; non-decimal values are blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Previous-cycle samples of the buttons and keypad for edge detection.
  // Sampled unconditionally so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    r_startn_q <= panel.startn;
    r_stopn_q  <= panel.stopn;
    r_keypad_q <= panel.keypad;
  end

  assign w_start_evt = ~panel.startn & r_startn_q;
  assign w_stop_evt  = ~panel.stopn & r_stopn_q;
  assign w_key_evt   = $onehot(panel.keypad) && (panel.keypad != r_keypad_q);
  assign w_time_dec  = bcd_dec(r_time);

  // One-hot keypad to digit value
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (panel.keypad[i]) w_digit = 4'(i);
    end
  end

  // Next-state, timer and prescaler; stop (or door open) outranks start
  always_comb begin
    w_state_nx = r_state;
    w_time_nx  = r_time;
    w_presc_nx = r_presc;
    case (r_state)
      ST_IDLE: begin
        if (w_start_evt && (r_time != 16'h0000) && panel.door_closed) begin
          w_state_nx = ST_COOK;
          w_presc_nx = '0;
        end else if (w_key_evt) begin
          w_time_nx = {r_time[11:0], w_digit};
        end
      end
      ST_COOK: begin
        if (w_stop_evt || !panel.door_closed) begin
          w_state_nx = ST_PAUSE;
        end else if (r_presc == c_TICK_LAST) begin
          w_presc_nx = '0;
          w_time_nx  = w_time_dec;
          if (w_time_dec == 16'h0000) w_state_nx = ST_IDLE;
        end else begin
          w_presc_nx = r_presc + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (w_stop_evt) begin
          w_state_nx = ST_IDLE;
          w_time_nx  = 16'h0000;
        end else if (w_start_evt && panel.door_closed) begin
          w_state_nx = ST_COOK;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register; clear is level-sensitive and behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst || !panel.clearn) begin
      r_state  <= ST_IDLE;
      r_time   <= 16'h0000;
      r_presc  <= '0;
      r_mag_on <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_time   <= w_time_nx;
      r_presc  <= w_presc_nx;
      r_mag_on <= (w_state_nx == ST_COOK);
    end
  end

  assign panel.mag_on        = r_mag_on;
  assign panel.sec_ones_segs = seg7(r_time[3:0]);
  assign panel.sec_tens_segs = seg7(r_time[7:4]);
`ifdef MW_LEADING_ZERO_BLANK_EN
  assign panel.min_tens_segs = (r_time[15:12] == 4'd0) ? 7'h00 : seg7(r_time[15:12]);
  assign panel.min_ones_segs = (r_time[15:8] == 8'h00) ? 7'h00 : seg7(r_time[11:8]);
`else
  assign panel.min_tens_segs = seg7(r_time[15:12]);
  assign panel.min_ones_segs = seg7(r_time[11:8]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_microwave_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_microwave_controller                                 |
// | Description : Directed self-checking bench for microwave_controller.  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_microwave_controller;

  localparam int TICK = 10;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S4 = 7'h66,
                         S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F,
                         S9 = 7'h6F;
`ifdef MW_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  microwave_controller_if pif ();

  microwave_controller #(.TICK_CYCLES(TICK)) dut (
    .clk   (clk),
    .rst   (rst),
    .panel (pif)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_mag(input string tag, input logic exp);
    n_checks++;
    assert (pif.mag_on === exp)
    else begin
      n_errors++;
      $error("FAIL %s mag_on observed=%b expected=%b", tag, pif.mag_on, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] mt, input logic [6:0] mo,
                          input logic [6:0] st, input logic [6:0] so);
    logic [27:0] obs;
    obs = {pif.min_tens_segs, pif.min_ones_segs, pif.sec_tens_segs, pif.sec_ones_segs};
    n_checks++;
    assert (obs === {mt, mo, st, so})
    else begin
      n_errors++;
      $error("FAIL %s segs observed=%h expected=%h", tag, obs, {mt, mo, st, so});
    end
  endtask

  task automatic key(input logic [9:0] k);
    pif.keypad = k;
    tick(1);
  endtask

  initial begin
    rst             = 1'b1;
    pif.keypad      = 10'h000;
    pif.startn      = 1'b1;
    pif.stopn       = 1'b1;
    pif.clearn      = 1'b1;
    pif.door_closed = 1'b1;
    tick(2);
    chk_mag("reset_mag", 1'b0);
    chk_disp("reset_disp", LZ, LZ, S0, S0);
    rst = 1'b0;
    tick(1);

    // Key 1 then key 2 with no release; holding 2 gives no extra shift
    key(10'h002);
    chk_disp("key1", LZ, LZ, S0, S1);
    key(10'h004);
    tick(2);
    key(10'h000);
    chk_disp("key12", LZ, LZ, S1, S2);
    chk_mag("key12_mag", 1'b0);

    // Start held low: single event, full 12 s countdown
    pif.startn = 1'b0;
    tick(1);
    chk_mag("start_mag", 1'b1);
    tick(TICK - 1);
    chk_disp("pre_tick", LZ, LZ, S1, S2);
    tick(1);
    chk_disp("tick1", LZ, LZ, S1, S1);
    tick(11 * TICK - 1);
    chk_disp("at_0001", LZ, LZ, S0, S1);
    chk_mag("at_0001_mag", 1'b1);
    tick(1);
    chk_disp("done", LZ, LZ, S0, S0);
    chk_mag("done_mag", 1'b0);
    tick(3);
    chk_mag("done_held_mag", 1'b0);
    pif.startn = 1'b1;
    tick(1);

    // 00:12, stop at 00:04 held for 1 s -> paused and frozen
    key(10'h002);
    key(10'h004);
    key(10'h000);
    pif.startn = 1'b0;
    tick(1);
    pif.startn = 1'b1;
    tick(8 * TICK);
    chk_disp("cook_0004", LZ, LZ, S0, S4);
    chk_mag("cook_0004_mag", 1'b1);
    pif.stopn = 1'b0;
    tick(TICK);
    pif.stopn = 1'b1;
    chk_mag("pause_mag", 1'b0);
    tick(4 * TICK);
    chk_disp("pause_frozen", LZ, LZ, S0, S4);

    // Stop in pause clears; start at 00:00 is ignored
    pif.stopn = 1'b0;
    tick(1);
    pif.stopn = 1'b1;
    tick(1);
    chk_disp("pause_stop_clr", LZ, LZ, S0, S0);
    pif.startn = 1'b0;
    tick(1);
    pif.startn = 1'b1;
    tick(1);
    chk_mag("start_zero_ign", 1'b0);

    // Keys 1,0,0 -> 01:00, one tick -> 00:59 (minute borrow)
    key(10'h002);
    key(10'h001);
    key(10'h000);
    key(10'h001);
    key(10'h000);
    chk_disp("entry_0100", LZ, S1, S0, S0);
    pif.startn = 1'b0;
    tick(1);
    pif.startn = 1'b1;
    tick(TICK);
    chk_disp("borrow_0059", LZ, LZ, S5, S9);
    chk_mag("borrow_mag", 1'b1);

    // Keypad ignored while cooking
    key(10'h008);
    key(10'h000);
    chk_disp("cook_key_ign", LZ, LZ, S5, S9);
    tick(1);

    // Door opens mid-cook: pause with prescaler held at 3
    pif.door_closed = 1'b0;
    tick(1);
    chk_mag("door_open_mag", 1'b0);
    tick(2 * TICK);
    chk_disp("door_open_held", LZ, LZ, S5, S9);
    pif.door_closed = 1'b1;
    tick(2);
    chk_mag("door_close_no_resume", 1'b0);
    pif.startn = 1'b0;
    tick(1);
    pif.startn = 1'b1;
    chk_mag("resume_mag", 1'b1);
    tick(6);
    chk_disp("resume_pre", LZ, LZ, S5, S9);
    tick(1);
    chk_disp("resume_0058", LZ, LZ, S5, S8);

    // Clear while cooking
    pif.clearn = 1'b0;
    tick(1);
    chk_disp("clear_disp", LZ, LZ, S0, S0);
    chk_mag("clear_mag", 1'b0);
    pif.clearn = 1'b1;
    tick(1);

    // Start with door open from IDLE is ignored
    key(10'h020);
    key(10'h000);
    pif.door_closed = 1'b0;
    pif.startn = 1'b0;
    tick(1);
    pif.startn = 1'b1;
    chk_mag("door_open_start_mag", 1'b0);
    tick(2 * TICK);
    chk_disp("door_open_start_disp", LZ, LZ, S0, S5);
    pif.door_closed = 1'b1;

    // Multi-hot keypad produces no event
    key(10'h006);
    key(10'h000);
    chk_disp("multihot_ign", LZ, LZ, S0, S5);

    // 05:70 counts down seconds above 59 unchanged
    key(10'h080);
    key(10'h001);
    key(10'h000);
    chk_disp("entry_0570", LZ, S5, S7, S0);
    pif.startn = 1'b0;
    tick(1);
    pif.startn = 1'b1;
    tick(TICK);
    chk_disp("cook_0569", LZ, S5, S6, S9);
    pif.clearn = 1'b0;
    tick(1);
    pif.clearn = 1'b1;
    chk_mag("final_clear_mag", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microwave_controller.md
Name: microwave_controller

Overview:
Microwave-oven front-panel controller. Accepts decimal keypad entry into an MM:SS BCD timer, counts down at 1 Hz while cooking and drives the magnetron enable. Handles start, stop, clear and door interlock. Drives four 7-segment digit displays; sits between the panel I/O and the magnetron driver.

Parameters:
TICK_CYCLES, 100, clk cycles per 1-second countdown tick (100 Hz system clock).

Ports:
clk  input  1  system clock (100 Hz nominal), all logic on rising edge
rst  input  1  synchronous, active-high reset
keypad  input  10  one-hot digit keys, bit n = digit n
startn  input  1  start button, active-low
stopn  input  1  stop/pause button, active-low
clearn  input  1  clear button, active-low, level-sensitive
door_closed  input  1  1 = door closed
mag_on  output  1  magnetron enable, registered
sec_ones_segs  output  7  seconds-ones digit segments {g,f,e,d,c,b,a}, active-high
sec_tens_segs  output  7  seconds-tens digit segments
min_ones_segs  output  7  minutes-ones digit segments
min_tens_segs  output  7  minutes-tens digit segments

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, all four BCD digits 0, prescaler 0, mag_on=0, all segs show "0" (7'h3F).
- Clear: clearn=0 sampled at any edge (when rst=0) has the same effect as reset; level-sensitive, dominates all other inputs except rst.
- Edge events: startn and stopn registered each cycle; an event fires on the edge where the sample is 0 and the previous sample was 1. Holding a button low gives exactly one event.
- Key press: fires when keypad is a valid one-hot value differing from the previous cycle's sample. Zero, multi-hot, or an unchanged value produces no event. Back-to-back different digits with no release in between both count.
- States: IDLE (entry), COOK, PAUSE.
- IDLE:
  - Key press shifts left: mt<=mo, mo<=st, st<=so, so<=digit; the old mt is discarded.
  - Start event with time≠00:00 and door_closed=1 -> COOK, prescaler=0.
  - Start otherwise is ignored.
- COOK:
  - mag_on=1 (registered; asserted the cycle after entry).
  - Prescaler increments each cycle; on reaching TICK_CYCLES-1 it wraps to 0 and time decrements by 1 s.
  - BCD decrement: so>0 -> so-1; else st>0 -> st-1, so=9; else mo/mt borrow as a BCD minute decrement with st=5, so=9.
  - Entered seconds above 59 count down unchanged until borrowed.
  - A decrement reaching 00:00 -> IDLE, mag_on=0.
  - Stop event -> PAUSE. Door open (door_closed=0) -> PAUSE.
  - Keypad ignored.
- PAUSE:
  - mag_on=0; time and prescaler held.
  - Start event with door_closed=1 -> COOK, prescaler kept.
  - Stop event -> clear time to 00:00, IDLE.
  - Keypad ignored.
- Simultaneous events: clear > stop > start; door-open in COOK is treated as stop.
- Segment map, a = bit0: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); values >9 display blank (00). Segment outputs are combinational from the registered digits.

Optional Feature:
MW_LEADING_ZERO_BLANK_EN:
- Defined: min_tens_segs blanks (7'h00) when mt=0; min_ones_segs also blanks when mt=0 and mo=0. Seconds digits always display.
- Undefined: all four digits always display, including zeros.

Test Plan:
- Reset, then key 1 then key 2 (keypad 0x002 -> 0x004, no release) -> display 00:12, mag_on=0.
- 00:12 entered, startn low and held, door closed -> mag_on=1 one cycle later; after 12×TICK_CYCLES cycles display 00:00, state IDLE, mag_on=0; a single start event only.
- Cooking from 00:12, stopn low at 8 s for 1 s then released -> PAUSE at 00:04, mag_on=0, display frozen 4 s later.
- Paused at 00:04: stop event -> 00:00 IDLE; a new start event from IDLE with 00:00 -> no effect.
- Keys 1,0,0 then start -> 01:00; after one tick 00:59, mag_on=1.
- Door opens mid-cook -> mag_on=0 next cycle, time held; door closes, then start -> resumes. Start with door open from IDLE -> ignored. clearn=0 in COOK -> 00:00, IDLE.
